// File: rtl/pe_op_sequencer.sv
// pe_op_sequencer
// Programmable op sequencer for one vectorized PE. A small program of {op, beats} entries is
// written over the cfg port while idle; after start, each entry drives the PE op for the
// requested number of accepted SIMD beats, raising tlast on the final beat of each entry.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   cfg_we/addr/op/beats  program entry write (IDLE only)
//   cfg_len, loop_en      entries to run and loop mode, latched on start
//   start, abort          run control (abort wins over start and beats)
//   i_tvalid1/2           observed PE lane valids
//   o_op, o_state         PE op and state controls
//   o_tlast               per-lane tlast for both PE inputs
//   o_busy, o_done        running flag, one-cycle end-of-program pulse
//   o_entry               current program entry
//   o_err                 sticky partial-lane-valid error
module pe_op_sequencer #(
    parameter int unsigned SIMD_degree = 16,
    parameter int unsigned NUM_ENTRIES = 8,
    parameter int unsigned BEAT_W      = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             cfg_we,
    input  logic [$clog2(NUM_ENTRIES)-1:0]   cfg_addr,
    input  logic [2:0]                       cfg_op,
    input  logic [BEAT_W-1:0]                cfg_beats,
    input  logic [$clog2(NUM_ENTRIES):0]     cfg_len,
    input  logic                             loop_en,
    input  logic                             start,
    input  logic                             abort,
    input  logic [SIMD_degree-1:0]           i_tvalid1,
    input  logic [SIMD_degree-1:0]           i_tvalid2,
    output logic [2:0]                       o_op,
    output logic [1:0]                       o_state,
    output logic [SIMD_degree-1:0]           o_tlast,
    output logic                             o_busy,
    output logic                             o_done,
    output logic [$clog2(NUM_ENTRIES)-1:0]   o_entry,
    output logic                             o_err
);

    localparam int unsigned EntryW = $clog2(NUM_ENTRIES);
    localparam int unsigned LenW   = EntryW + 1;

    // Op encodings shared with the PE: NOP=0, ADD=1, MUL=2, MACC=3.
    localparam logic [2:0] OpNop        = 3'd0;
    localparam logic [1:0] StatePayload = 2'b01;

    typedef enum logic {StIdle, StRun} fsmState_t;

    fsmState_t            stateQ, stateD;
    logic [EntryW-1:0]    entryQ, entryD;
    logic [BEAT_W-1:0]    beatCntQ, beatCntD;
    logic [LenW-1:0]      lenQ, lenD;
    logic                 loopQ, loopD;
    logic                 errQ, errD;
    logic                 doneQ, doneD;

    // Program memory: deliberately not reset so a program survives rst.
    logic [2:0]           progOp    [NUM_ENTRIES];
    logic [BEAT_W-1:0]    progBeats [NUM_ENTRIES];

    always_ff @(posedge clk) begin
        if (cfg_we && stateQ == StIdle) begin
            progOp[cfg_addr]    <= cfg_op;
            progBeats[cfg_addr] <= cfg_beats;
        end
    end

    logic [2:0]        curOp;
    logic [BEAT_W-1:0] curBeats;
    logic [BEAT_W-1:0] lastCnt;
    logic              isRun;
    logic              atLastBeat;
    logic              lastEntry;
    logic              needV2;
    logic              v1Partial;
    logic              v2Partial;
    logic              accept;

    always_comb begin
        curOp      = progOp[entryQ];
        curBeats   = progBeats[entryQ];
        // A zero beat count behaves as a single beat.
        lastCnt    = (curBeats == '0) ? '0 : curBeats - BEAT_W'(1);
        isRun      = (stateQ == StRun);
        atLastBeat = (beatCntQ == lastCnt);
        lastEntry  = ({1'b0, entryQ} == lenQ - LenW'(1));
        needV2     = (curOp != OpNop);
        v1Partial  = (|i_tvalid1) && !(&i_tvalid1);
        v2Partial  = needV2 && (|i_tvalid2) && !(&i_tvalid2);
        accept     = isRun && (&i_tvalid1) && (!needV2 || (&i_tvalid2));
    end

    always_comb begin
        stateD   = stateQ;
        entryD   = entryQ;
        beatCntD = beatCntQ;
        lenD     = lenQ;
        loopD    = loopQ;
        errD     = errQ;
        doneD    = 1'b0;
        unique case (stateQ)
            StIdle: begin
                if (!abort && start && cfg_len != '0) begin
                    stateD   = StRun;
                    entryD   = '0;
                    beatCntD = '0;
                    lenD     = cfg_len;
                    loopD    = loop_en;
                    errD     = 1'b0;
                end
            end
            StRun: begin
                if (abort) begin
                    stateD   = StIdle;
                    entryD   = '0;
                    beatCntD = '0;
                end else begin
                    if (v1Partial || v2Partial) begin
                        errD = 1'b1;
                    end
                    if (accept) begin
                        if (atLastBeat) begin
                            beatCntD = '0;
                            if (!lastEntry) begin
                                entryD = entryQ + EntryW'(1);
                            end else if (loopQ) begin
                                entryD = '0;
                            end else begin
                                stateD = StIdle;
                                entryD = '0;
                                doneD  = 1'b1;
                            end
                        end else begin
                            beatCntD = beatCntQ + BEAT_W'(1);
                        end
                    end
                end
            end
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ   <= StIdle;
            entryQ   <= '0;
            beatCntQ <= '0;
            lenQ     <= '0;
            loopQ    <= 1'b0;
            errQ     <= 1'b0;
            doneQ    <= 1'b0;
        end else begin
            stateQ   <= stateD;
            entryQ   <= entryD;
            beatCntQ <= beatCntD;
            lenQ     <= lenD;
            loopQ    <= loopD;
            errQ     <= errD;
            doneQ    <= doneD;
        end
    end

    // Op and tlast come straight from registers so entry changes need no bubble cycle.
    always_comb begin
        o_op    = isRun ? curOp : OpNop;
        o_state = isRun ? StatePayload : 2'b00;
        o_tlast = (isRun && atLastBeat) ? '1 : '0;
        o_busy  = isRun;
        o_done  = doneQ;
        o_entry = entryQ;
        o_err   = errQ;
    end

endmodule

// File: tb/tb_pe_op_sequencer.sv
module tb_pe_op_sequencer;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_MUL  = 3'd2;
    localparam logic [2:0] OP_MACC = 3'd3;
    localparam logic [1:0] PAYLOAD = 2'b01;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_addr = '0;
    logic [2:0]  cfg_op = '0;
    logic [15:0] cfg_beats = '0;
    logic [3:0]  cfg_len = '0;
    logic        loop_en = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] i_tvalid1 = '0;
    logic [15:0] i_tvalid2 = '0;
    logic [2:0]  o_op;
    logic [1:0]  o_state;
    logic [15:0] o_tlast;
    logic        o_busy;
    logic        o_done;
    logic [2:0]  o_entry;
    logic        o_err;

    int checks = 0;
    int passed = 0;

    pe_op_sequencer #(
        .SIMD_degree(16),
        .NUM_ENTRIES(8),
        .BEAT_W     (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_op   (cfg_op),
        .cfg_beats(cfg_beats),
        .cfg_len  (cfg_len),
        .loop_en  (loop_en),
        .start    (start),
        .abort    (abort),
        .i_tvalid1(i_tvalid1),
        .i_tvalid2(i_tvalid2),
        .o_op     (o_op),
        .o_state  (o_state),
        .o_tlast  (o_tlast),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_entry  (o_entry),
        .o_err    (o_err)
    );

    always #5 clk = ~clk;

    logic [26:0] obs;
    assign obs = {o_op, o_state, o_tlast, o_busy, o_done, o_entry, o_err};

    // Expected output vector: {op, state, tlast, busy, done, entry, err}.
    function automatic logic [26:0] row(input logic [2:0] op, input logic tl, input logic busy,
                                        input logic done, input logic [2:0] ent,
                                        input logic err);
        return {op, busy ? PAYLOAD : 2'b00, tl ? 16'hFFFF : 16'h0000, busy, done, ent, err};
    endfunction

    task automatic write_entry(input logic [2:0] addr, input logic [2:0] op,
                               input logic [15:0] beats);
        cfg_we = 1'b1; cfg_addr = addr; cfg_op = op; cfg_beats = beats;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic do_start(input logic [3:0] len, input logic lp);
        cfg_len = len; loop_en = lp; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        logic [26:0] e;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        e = row(OP_NOP, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        checks++;
        if (obs !== e) $display("FAIL reset: got %h expected %h", obs, e); else passed++;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== e) $display("FAIL reset_release: got %h expected %h", obs, e); else passed++;
    endtask

    task automatic test_len_zero();
        logic [26:0] e;
        write_entry(3'd0, OP_MACC, 16'd3);
        do_start(4'd0, 1'b0);
        e = row(OP_NOP, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        checks++;
        if (obs !== e) $display("FAIL len_zero: got %h expected %h", obs, e); else passed++;
    endtask

    task automatic test_basic();
        logic [26:0] e [$];
        write_entry(3'd0, OP_MACC, 16'd3);
        write_entry(3'd1, OP_NOP, 16'd1);
        i_tvalid1 = 16'hFFFF; i_tvalid2 = 16'hFFFF;
        e.push_back(row(OP_MACC, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0));
        e.push_back(row(OP_MACC, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0));
        e.push_back(row(OP_MACC, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0));
        e.push_back(row(OP_NOP,  1'b1, 1'b1, 1'b0, 3'd1, 1'b0));
        e.push_back(row(OP_NOP,  1'b0, 1'b0, 1'b1, 3'd0, 1'b0));
        e.push_back(row(OP_NOP,  1'b0, 1'b0, 1'b0, 3'd0, 1'b0));
        do_start(4'd2, 1'b0);
        for (int i = 0; i < e.size(); i++) begin
            checks++;
            if (obs !== e[i]) $display("FAIL basic[%0d]: got %h expected %h", i, obs, e[i]);
            else passed++;
            @(negedge clk);
        end
    endtask

    task automatic test_stall();
        logic [26:0] e [$];
        for (int i = 0; i < 6; i++) e.push_back(row(OP_MACC, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0));
        e.push_back(row(OP_MACC, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0));
        e.push_back(row(OP_NOP,  1'b1, 1'b1, 1'b0, 3'd1, 1'b0));
        e.push_back(row(OP_NOP,  1'b0, 1'b0, 1'b1, 3'd0, 1'b0));
        do_start(4'd2, 1'b0);
        for (int i = 0; i < e.size(); i++) begin
            checks++;
            if (obs !== e[i]) $display("FAIL stall[%0d]: got %h expected %h", i, obs, e[i]);
            else passed++;
            i_tvalid2 = (i < 4) ? 16'h0000 : 16'hFFFF;
            @(negedge clk);
        end
    endtask

    task automatic test_nop_only();
        logic [26:0] e [$];
        write_entry(3'd0, OP_NOP, 16'd2);
        // Partial tvalid2 must be ignored under NOP.
        i_tvalid2 = 16'h00F0;
        e.push_back(row(OP_NOP, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0));
        e.push_back(row(OP_NOP, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0));
        e.push_back(row(OP_NOP, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0));
        do_start(4'd1, 1'b0);
        for (int i = 0; i < e.size(); i++) begin
            checks++;
            if (obs !== e[i]) $display("FAIL nop_only[%0d]: got %h expected %h", i, obs, e[i]);
            else passed++;
            @(negedge clk);
        end
        i_tvalid2 = 16'hFFFF;
    endtask

    task automatic test_loop_abort();
        logic [26:0] e;
        write_entry(3'd0, OP_ADD, 16'd0);
        do_start(4'd1, 1'b1);
        e = row(OP_ADD, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (obs !== e) $display("FAIL loop[%0d]: got %h expected %h", i, obs, e); else passed++;
            @(negedge clk);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        e = row(OP_NOP, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        checks++;
        if (obs !== e) $display("FAIL abort: got %h expected %h", obs, e); else passed++;
        @(negedge clk);
        checks++;
        if (obs !== e) $display("FAIL abort_no_done: got %h expected %h", obs, e); else passed++;
    endtask

    task automatic test_err();
        logic [26:0] e [$];
        logic [26:0] x;
        write_entry(3'd0, OP_MUL, 16'd2);
        e.push_back(row(OP_MUL, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0));
        e.push_back(row(OP_MUL, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1));
        e.push_back(row(OP_MUL, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1));
        e.push_back(row(OP_NOP, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1));
        e.push_back(row(OP_NOP, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1));
        do_start(4'd1, 1'b0);
        for (int i = 0; i < e.size(); i++) begin
            checks++;
            if (obs !== e[i]) $display("FAIL err[%0d]: got %h expected %h", i, obs, e[i]);
            else passed++;
            i_tvalid1 = (i == 0) ? 16'h00FF : 16'hFFFF;
            @(negedge clk);
        end
        do_start(4'd1, 1'b0);
        x = row(OP_MUL, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
        checks++;
        if (obs !== x) $display("FAIL err_clear: got %h expected %h", obs, x); else passed++;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [26:0] e [$];
        logic [26:0] x;
        write_entry(3'd0, OP_MACC, 16'd2);
        write_entry(3'd1, OP_ADD, 16'd1);
        e.push_back(row(OP_MACC, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0));
        e.push_back(row(OP_MACC, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0));
        e.push_back(row(OP_ADD,  1'b1, 1'b1, 1'b0, 3'd1, 1'b0));
        e.push_back(row(OP_NOP,  1'b0, 1'b0, 1'b1, 3'd0, 1'b0));
        do_start(4'd2, 1'b0);
        for (int i = 0; i < e.size(); i++) begin
            checks++;
            if (obs !== e[i]) $display("FAIL cfg_we_run[%0d]: got %h expected %h", i, obs, e[i]);
            else passed++;
            // Attempted rewrite of entry 1 while running must be dropped.
            cfg_we = (i == 0); cfg_addr = 3'd1; cfg_op = OP_MUL; cfg_beats = 16'd5;
            @(negedge clk);
        end
        cfg_we = 1'b0;
        do_start(4'd2, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        x = row(OP_NOP, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        checks++;
        if (obs !== x) $display("FAIL rst_mid_run: got %h expected %h", obs, x); else passed++;
        do_start(4'd2, 1'b0);
        for (int i = 0; i < e.size(); i++) begin
            checks++;
            if (obs !== e[i]) $display("FAIL rerun[%0d]: got %h expected %h", i, obs, e[i]);
            else passed++;
            start = (i == 3);
            @(negedge clk);
        end
        start = 1'b0;
        x = row(OP_MACC, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
        checks++;
        if (obs !== x) $display("FAIL back_to_back: got %h expected %h", obs, x); else passed++;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    initial begin
        test_reset();
        test_len_zero();
        test_basic();
        test_stall();
        test_nop_only();
        test_loop_abort();
        test_err();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
